// File: rtl/fp_mul_seq.sv
// Sequential binary32 multiplier: 24-cycle shift-and-add mantissa product,
// one normalisation cycle, truncating rounding, flush-to-zero denormals.
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned WW      = 32;
    localparam int unsigned EW      = 8;
    localparam int unsigned FW      = 23;
    localparam int unsigned MW      = FW + 1;
    localparam int unsigned PW      = 2 * MW;
    localparam int unsigned CW      = 5;
    localparam int unsigned XW      = EW + 2;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned LAST_IT = MW - 1;

    localparam logic [WW-1:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched operand fields and iteration state
    logic          sign_q;
    logic [EW-1:0] ea_q;
    logic [EW-1:0] eb_q;
    logic [FW-1:0] fb_q;
    logic [MW-1:0] ma_q;
    logic [MW-1:0] mb_q;
    logic [PW-1:0] p_q;
    logic [CW-1:0] cnt_q;

    logic          load;
    logic          step;
    logic          finish;
    logic          busy_d;
    logic          done_d;
    logic          last_iter;

    assign last_iter = (cnt_q == CW'(LAST_IT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_MUL;
            S_MUL:   if (last_iter) state_d = S_NORM;
            S_NORM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and next-output decode
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                load   = start;
                busy_d = start;
            end
            S_MUL: begin
                step   = 1'b1;
                busy_d = 1'b1;
            end
            S_NORM: begin
                finish = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand latch and shift-and-add datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            ea_q   <= '0;
            eb_q   <= '0;
            fb_q   <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sign_q <= A[WW-1] ^ B[WW-1];
            ea_q   <= A[WW-2:FW];
            eb_q   <= B[WW-2:FW];
            fb_q   <= B[FW-1:0];
            ma_q   <= {1'b1, A[FW-1:0]};
            mb_q   <= {1'b1, B[FW-1:0]};
            p_q    <= '0;
            cnt_q  <= '0;
        end else if (step) begin
            if (mb_q[0]) begin
                p_q <= p_q + (PW'(ma_q) << cnt_q);
            end
            mb_q  <= mb_q >> 1;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Normalisation and special-case resolution
    logic [FW-1:0] fa;
    logic          a_max;
    logic          b_max;
    logic          a_zero;
    logic          b_zero;
    logic          a_nan;
    logic          b_nan;
    logic [XW-1:0] e_raw;
    logic [XW-1:0] e_adj;
    logic [FW-1:0] frac;
    logic          ovf;
    logic          unf;
    logic [WW-1:0] norm_result;

    assign fa     = ma_q[FW-1:0];
    assign a_max  = (ea_q == '1);
    assign b_max  = (eb_q == '1);
    assign a_zero = (ea_q == '0);
    assign b_zero = (eb_q == '0);
    assign a_nan  = a_max && (fa != '0);
    assign b_nan  = b_max && (fb_q != '0);

    // Exponent held as 10-bit two's complement so underflow shows as bit 9
    assign e_raw  = XW'(ea_q) + XW'(eb_q) - XW'(BIAS);
    assign e_adj  = e_raw + XW'(p_q[PW-1]);
    assign frac   = p_q[PW-1] ? p_q[PW-2:MW] : p_q[PW-3:FW];
    assign ovf    = !e_adj[XW-1] && (e_adj >= XW'(255));
    assign unf    = e_adj[XW-1] || (e_adj == '0);

    always_comb begin
        norm_result = {sign_q, e_adj[EW-1:0], frac};
        if (a_nan || b_nan || (a_max && b_zero) || (b_max && a_zero)) begin
            norm_result = QNAN;
        end else if (a_max || b_max) begin
            norm_result = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
        end else if (a_zero || b_zero) begin
            norm_result = {sign_q, {(WW-1){1'b0}}};
        end else if (ovf) begin
            norm_result = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
        end else if (unf) begin
            norm_result = {sign_q, {(WW-1){1'b0}}};
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (finish) begin
                result <= norm_result;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: products, specials, handshake timing and
// asynchronous reset abort, all against hand-computed constants.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_bad;

    fp_mul_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation; returns once done has been sampled (just after edge k+25)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        lat = 0;
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        chk({tag, ":busy_at_k"}, 32'(busy), 32'd1);
        chk({tag, ":done_at_k"}, 32'(done), 32'd0);
        while (!done && lat < 40) begin
            if (lat == 24) chk({tag, ":busy_at_k24"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'd25);
        chk({tag, ":result"}, result, exp);
        chk({tag, ":busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:done", 32'(done), 32'd0);
        chk("reset:result", result, 32'h0000_0000);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "2x3");
        @(posedge clk);
        #1;
        chk("2x3:done_single", 32'(done), 32'd0);
        chk("2x3:result_hold", result, 32'h40C0_0000);
        @(negedge clk);

        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "1p5sq");
        @(negedge clk);
        run_op(32'hBF80_0000, 32'h3EAA_AAAB, 32'hBEAA_AAAB, "neg_third");
        @(negedge clk);
        run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "trunc");
        @(negedge clk);
        run_op(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, "negzero");
        @(negedge clk);
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_x_zero");
        @(negedge clk);
        run_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, "inf_x_neg");
        @(negedge clk);
        run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, "overflow");
        @(negedge clk);
        run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, "underflow");
        @(negedge clk);
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");

        // Back-to-back: second start sampled on the edge right after the done cycle
        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "b2b_1");
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "b2b_2");
        @(negedge clk);

        // Start re-pulsed mid-operation must be ignored
        fork
            run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "repulse");
            begin
                repeat (6) @(posedge clk);
                #2;
                start = 1'b1;
                A     = 32'h3FC0_0000;
                B     = 32'h3FC0_0000;
                @(posedge clk);
                #2;
                start = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        chk("repulse:no_extra_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Asynchronous reset at MUL iteration 10
        start = 1'b1;
        A     = 32'h3FC0_0000;
        B     = 32'h4040_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort:busy", 32'(busy), 32'd0);
        chk("abort:done", 32'(done), 32'd0);
        chk("abort:result", result, 32'h0000_0000);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort:no_done", 32'(ndone), 32'd0);
        @(negedge clk);
        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
